add_sub_unit: RTL and testbench
===============================

# add_sub_unit

Parametrised, pipelined integer add/subtract unit for the ALU datapath, successor to the single-cycle registered 16-bit adder. It supports ADD, SUB, ADC and SBC on WIDTH-bit operands and produces N/Z/C/V flags. The carry chain is split across STAGES pipeline stages. A valid/ready handshake on both sides carries backpressure from the writeback path.

## Interface
Parameters:
- WIDTH, 16: operand/result width; must be a multiple of STAGES, minimum 4.
- STAGES, 2: pipeline depth; each stage adds WIDTH/STAGES bits of the carry chain; 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  unit accepts the request this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  2  0=ADD, 1=SUB, 2=ADC, 3=SBC.
- in_cin  in  1  carry in; used by ADC/SBC only.
- in_sat  in  1  saturating request; present only with SATURATE_EN.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result this cycle.
- out_result  out  WIDTH  result.
- out_flags  out  4  {N,Z,C,V}.

## Operation
- Effective operation: B' = in_b for ADD/ADC and ~in_b for SUB/SBC. Carry in c0 = 0 for ADD, 1 for SUB, and in_cin for ADC/SBC. The sum is in_a + B' + c0, truncated to WIDTH bits.
- C: carry out of bit WIDTH-1. For SUB, C=1 means no borrow.
- V: carry into MSB XOR carry out of MSB.
- N: result MSB.
- Z: result == 0. Z is computed as the AND of the per-chunk zero bits propagated through the stages.
- Stage k (0-based) adds chunk k, bits [k*W/S +: W/S], using the carry from stage k-1.
  - Chunks not yet added are carried forward in skew registers.
  - Completed chunks are carried forward unchanged.
- Each stage holds a valid bit. Each stage's valid bit and the out_* registers reset to 0.
- Stall rule: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every stage and every output register holds its value.
  - While not stalled, all stages shift by one. An empty stage (valid=0) is filled by the stage behind it, or by the input when in_valid && in_ready.
- A request is accepted on a cycle with in_valid && in_ready.
- A result is consumed on a cycle with out_valid && out_ready.
- Bubbles propagate as valid=0. Data registers of invalid stages may hold stale values; out_result and out_flags are meaningful only while out_valid=1.

## Timing
- Latency: a request accepted at edge t appears with out_valid=1 after edge t+STAGES.
- Throughput: one result per cycle while out_ready is held at 1.
- Simultaneous accept and consume in the same cycle is legal and loses no data.
- Reset values: out_valid=0, out_result=0, out_flags=0, all stage valids=0.
  - in_ready is 1 during reset, because out_valid=0.
- Reset mid-operation: all in-flight operations are discarded immediately and asynchronously. There is no partial output after release.
- in_* inputs are sampled only at acceptance. Input changes while in_ready=0 have no effect.
- Output stability: out_result and out_flags are stable while stalled.

## Configuration
- Macro: ADD_SUB_UNIT_SATURATE_EN.
- Defined:
  - The in_sat port exists.
  - When in_sat=1 and V=1, the result is clamped to the signed limit. If the operand A MSB is 0, the result is 0111..1; if it is 1, the result is 1000..0.
  - In the clamped case, the flags are recomputed on the clamped value (N and Z follow the clamped result), and C and V keep their unclamped values.
  - The clamp is applied in the final stage, so latency is unchanged.
- Undefined: there is no in_sat port and results always wrap modulo 2^WIDTH.

## Structure
- Shared package alu_pkg holds:
  - the op encoding constants (OP_ADD, OP_SUB, OP_ADC, OP_SBC);
  - the flag index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0);
  - the packed flags typedef.
- Sub-module add_sub_chunk: a combinational W/S-bit adder with carry in/out and a chunk-zero output. It is instantiated once per stage by a generate loop.
- The top level holds the valid/stall control, the skew registers and the final flag/saturation logic.

## Test plan
- Config WIDTH=16, STAGES=2, out_ready=1: ADD 0x0003+0x0004 -> 0x0007 with flags 0000, out_valid exactly 2 cycles after accept.
- ADD 0xFFFF+0x0001 -> 0x0000, Z=1, C=1, V=0. SUB 0x0005-0x0007 -> 0xFFFE, N=1, C=0.
- ADD 0x7FFF+0x0001 -> 0x8000, N=1, V=1. With SATURATE_EN and in_sat=1 -> 0x7FFF, N=0, V=1. SBC 0x0000-0x0000 with cin=0 -> 0xFFFF, C=0.
- Back-to-back stream of 8 ADDs with out_ready toggled 1,0,0,1 repeating: all 8 results emerge in order, none lost or duplicated, in_ready low exactly on stall cycles.
- Reset asserted with 2 operations in flight: out_valid=0 immediately; after release, no result appears until a new accept.
- Config WIDTH=32, STAGES=4: ADC 0x0000FFFF+0x00000001 with cin=1 -> 0x00010001, flags 0000, latency 4.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU encodings, flag layout and add/sub control bundle.
// Optional field sat exists only with ADD_SUB_UNIT_SATURATE_EN.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ADC = 2'd2;
  localparam logic [1:0] OP_SBC = 2'd3;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Per-stage control travelling with each chunk of an operation.
  // c is the running carry, z the running AND of chunk-zero bits,
  // am/bm the MSBs of A and the effective B (for V and the clamp).
  typedef struct packed {
    logic vld;
    logic c;
    logic z;
    logic am;
    logic bm;
`ifdef ADD_SUB_UNIT_SATURATE_EN
    logic sat;
`endif
  } add_sub_ctl_t;

endpackage

// File: rtl/add_sub_chunk.sv
// add_sub_chunk: combinational W-bit adder slice with carry and zero.
// Ports: a_i, b_i, cin_i in; sum_o, cout_o, zero_o out.
module add_sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         zero_o
);

  assign {cout_o, sum_o} = {1'b0, a_i}
                         + {1'b0, b_i}
                         + {{W{1'b0}}, cin_i};

  assign zero_o = (sum_o == '0);

endmodule

// File: rtl/add_sub_unit.sv
// add_sub_unit: pipelined ADD/SUB/ADC/SBC with N/Z/C/V and valid/ready.
// Ports: clk, rst (async low), in_* request side, out_* result side.
// Macro ADD_SUB_UNIT_SATURATE_EN adds in_sat and signed clamping.
module add_sub_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
`ifdef ADD_SUB_UNIT_SATURATE_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);

  localparam int CW = WIDTH / STAGES;

  // Operand bits still to be added are packed triangularly:
  // stage k forwards WIDTH-(k+1)*CW bits, the last forwards none.
  localparam int OPW_RAW = (STAGES - 1) * WIDTH
                         - CW * (STAGES - 1) * STAGES / 2;
  localparam int OPW = (OPW_RAW > 0) ? OPW_RAW : 1;

  // Finished chunks grow by CW per stage: stage k holds (k+1)*CW.
  localparam int RWT = CW * STAGES * (STAGES + 1) / 2;
  localparam int ROL = CW * (STAGES - 1) * STAGES / 2;

  logic                    stall;
  logic                    acc;
  logic [WIDTH-1:0]        bx;
  logic                    c0;
  add_sub_ctl_t            in_ctl;

  logic [OPW-1:0]          a_d, a_q;
  logic [OPW-1:0]          b_d, b_q;
  logic [RWT-1:0]          r_d, r_q;
  add_sub_ctl_t [STAGES-1:0] c_d, c_q;

  logic                    ov_d, ov_q;
  logic [WIDTH-1:0]        res_d, res_q;
  flags_t                  flg_d, flg_q;

  assign stall    = ov_q && !out_ready;
  assign in_ready = !stall;
  assign acc      = in_valid && in_ready;

  always_comb begin
    bx = in_b;
    c0 = 1'b0;
    unique case (in_op)
      OP_ADD: begin
        bx = in_b;
        c0 = 1'b0;
      end
      OP_SUB: begin
        bx = ~in_b;
        c0 = 1'b1;
      end
      OP_ADC: begin
        bx = in_b;
        c0 = in_cin;
      end
      OP_SBC: begin
        bx = ~in_b;
        c0 = in_cin;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ctl     = '0;
    in_ctl.vld = acc;
    in_ctl.c   = c0;
    in_ctl.z   = 1'b1;
    in_ctl.am  = in_a[WIDTH-1];
    in_ctl.bm  = bx[WIDTH-1];
`ifdef ADD_SUB_UNIT_SATURATE_EN
    in_ctl.sat = in_sat;
`endif
  end

  if (OPW_RAW == 0) begin : g_noops
    assign a_d = '0;
    assign b_d = '0;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int PI = WIDTH - k * CW;
    localparam int PO = PI - CW;
    localparam int RO = CW * k * (k + 1) / 2;

    logic [PI-1:0] sa;
    logic [PI-1:0] sb;
    add_sub_ctl_t  s;
    add_sub_ctl_t  nx;
    logic [CW-1:0] sum;
    logic          co;
    logic          zo;

    if (k == 0) begin : g_src
      assign sa = in_a;
      assign sb = bx;
      assign s  = in_ctl;
      assign r_d[RO +: CW] = sum;
    end else begin : g_src
      localparam int OI = (k - 1) * WIDTH
                        - CW * (k - 1) * k / 2;
      localparam int RI = CW * (k - 1) * k / 2;
      assign sa = a_q[OI +: PI];
      assign sb = b_q[OI +: PI];
      assign s  = c_q[k-1];
      assign r_d[RO +: (k+1)*CW] =
        {sum, r_q[RI +: k*CW]};
    end

    if (PO > 0) begin : g_fwd
      localparam int OO = k * WIDTH
                        - CW * k * (k + 1) / 2;
      assign a_d[OO +: PO] = sa[PI-1:CW];
      assign b_d[OO +: PO] = sb[PI-1:CW];
    end

    add_sub_chunk #(
      .W(CW)
    ) u_chunk (
      .a_i   (sa[CW-1:0]),
      .b_i   (sb[CW-1:0]),
      .cin_i (s.c),
      .sum_o (sum),
      .cout_o(co),
      .zero_o(zo)
    );

    always_comb begin
      nx   = s;
      nx.c = co;
      nx.z = s.z & zo;
    end

    assign c_d[k] = nx;
  end

  add_sub_ctl_t     lc;
  logic [WIDTH-1:0] wrap;
  logic [WIDTH-1:0] res;
  logic             v;
  logic             clamp;
  logic [3:0]       fv;

  always_comb begin
    lc    = c_q[STAGES-1];
    wrap  = r_q[ROL +: WIDTH];
    // carry into MSB is a^b^sum at that bit
    v     = lc.am ^ lc.bm ^ wrap[WIDTH-1] ^ lc.c;
    res   = wrap;
    clamp = 1'b0;
`ifdef ADD_SUB_UNIT_SATURATE_EN
    clamp = lc.sat & v;
    if (clamp) begin
      res = lc.am ? {1'b1, {(WIDTH-1){1'b0}}}
                  : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    fv         = '0;
    fv[FLAG_N] = res[WIDTH-1];
    // a clamped value is never zero
    fv[FLAG_Z] = lc.z & ~clamp;
    fv[FLAG_C] = lc.c;
    fv[FLAG_V] = v;
  end

  assign ov_d  = lc.vld;
  assign res_d = res;
  assign flg_d = fv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      c_q   <= '0;
      ov_q  <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
    end else if (!stall) begin
      a_q   <= a_d;
      b_q   <= b_d;
      r_q   <= r_d;
      c_q   <= c_d;
      ov_q  <= ov_d;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_result = res_q;
  assign out_flags  = flg_q;

endmodule

// File: tb/tb_add_sub_unit.sv
// tb_add_sub_unit: directed checks of add_sub_unit in 16/2 and 32/4.
// Scoreboard model on plain integer arithmetic; literal pins on model.
module tb_add_sub_unit;
  import alu_pkg::*;

  localparam int S16 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        iv = 1'b0, ir, ov, ordy = 1'b1;
  logic [15:0] ia = '0, ib = '0, ores;
  logic [1:0]  iop = '0;
  logic        icin = 1'b0, isat = 1'b0;
  logic [3:0]  ofl;

  logic        iv32 = 1'b0, ir32, ov32, ordy32 = 1'b1;
  logic [31:0] ia32 = '0, ib32 = '0, ores32;
  logic [1:0]  iop32 = '0;
  logic        icin32 = 1'b0;
  logic [3:0]  ofl32;

  add_sub_unit #(.WIDTH(16), .STAGES(2)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir),
    .in_a(ia), .in_b(ib), .in_op(iop), .in_cin(icin),
`ifdef ADD_SUB_UNIT_SATURATE_EN
    .in_sat(isat),
`endif
    .out_valid(ov), .out_ready(ordy),
    .out_result(ores), .out_flags(ofl)
  );

  add_sub_unit #(.WIDTH(32), .STAGES(4)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(ir32),
    .in_a(ia32), .in_b(ib32), .in_op(iop32), .in_cin(icin32),
`ifdef ADD_SUB_UNIT_SATURATE_EN
    .in_sat(1'b0),
`endif
    .out_valid(ov32), .out_ready(ordy32),
    .out_result(ores32), .out_flags(ofl32)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int consumed = 0;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  f;
    int          due;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // {N,Z,C,V, result} from the arithmetic definition
  function automatic logic [35:0] model(input int w,
      input logic [31:0] a, input logic [31:0] b,
      input logic [1:0] op, input logic cin, input logic sat);
    longint unsigned mask, aa, bb, s, r, c0, msb;
    logic n, z, c, v;
    mask = (64'd1 << w) - 1;
    aa = 64'(a) & mask;
    bb = 64'(b) & mask;
    if (op == OP_SUB || op == OP_SBC) bb = ~bb & mask;
    case (op)
      OP_ADD:  c0 = 0;
      OP_SUB:  c0 = 1;
      default: c0 = 64'(cin);
    endcase
    s = aa + bb + c0;
    r = s & mask;
    c = ((s >> w) & 1) != 0;
    msb = 64'd1 << (w - 1);
    v = ((aa & msb) == (bb & msb)) && ((r & msb) != (aa & msb));
    if (sat && v) r = ((aa & msb) != 0) ? msb : (msb - 1);
    n = (r & msb) != 0;
    z = (r == 0);
    return {n, z, c, v, 32'(r)};
  endfunction

  // out_ready pattern source: hold value or 1,0,0,1 repeating
  logic tog = 1'b0;
  logic hold = 1'b1;
  int   tp = 0;
  always @(posedge clk) begin
    #1;
    if (tog) begin
      ordy = (tp % 4 == 0) || (tp % 4 == 3);
      tp++;
    end else begin
      ordy = hold;
    end
  end

  // scoreboard compare on every negedge out of reset
  always @(negedge clk) begin
    logic [35:0] m;
    exp_t e;
    if (rst) begin
      if (ov) begin
        chk("valid_has_entry", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          chk("result", ores, q[0].r);
          chk("flags", ofl, q[0].f);
          chk("not_early", 64'(q[0].due <= cyc), 1);
          if (ordy) begin
            void'(q.pop_front());
            consumed++;
          end
        end
      end
      chk("in_ready", ir, !(ov && !ordy));
      if (iv && ir) begin
        m = model(16, 32'(ia), 32'(ib), iop, icin, isat);
        e.r = m[15:0];
        e.f = m[35:32];
        e.due = cyc + 1 + S16;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] op, input logic cin,
                      input logic sat);
    int n;
    logic ok;
    iv = 1'b1; ia = a; ib = b; iop = op; icin = cin; isat = sat;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = ir;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept", ok, 1);
    iv = 1'b0;
    isat = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int c0;
    logic [35:0] m;

    #12;
    chk("rst_valid", ov, 0);
    chk("rst_result", ores, 0);
    chk("rst_flags", ofl, 0);
    chk("rst_ready", ir, 1);
    chk("rst_valid32", ov32, 0);

    m = model(16, 32'h3, 32'h4, OP_ADD, 1'b0, 1'b0);
    chk("pin_add", m, {4'b0000, 32'h7});
    m = model(16, 32'hFFFF, 32'h1, OP_ADD, 1'b0, 1'b0);
    chk("pin_wrap", m, {4'b0110, 32'h0});
    m = model(16, 32'h5, 32'h7, OP_SUB, 1'b0, 1'b0);
    chk("pin_sub", m, {4'b1000, 32'hFFFE});
    chk("pin_sub_C", m[32+FLAG_C], 0);
    m = model(16, 32'h7FFF, 32'h1, OP_ADD, 1'b0, 1'b0);
    chk("pin_ovf", m, {4'b1001, 32'h8000});
    m = model(16, 32'h7FFF, 32'h1, OP_ADD, 1'b0, 1'b1);
    chk("pin_sat", m, {4'b0001, 32'h7FFF});
    m = model(16, 32'h0, 32'h0, OP_SBC, 1'b0, 1'b0);
    chk("pin_sbc", m, {4'b1000, 32'hFFFF});
    chk("pin_sbc_N", m[32+FLAG_N], 1);
    m = model(32, 32'h0000FFFF, 32'h1, OP_ADC, 1'b1, 1'b0);
    chk("pin_adc32", m, {4'b0000, 32'h00010001});

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    send(16'h0003, 16'h0004, OP_ADD, 1'b0, 1'b0);
    lat = 0;
    while (!ov && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency16", lat, S16);
    drain();

    send(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, OP_SUB, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1'b0);
    send(16'h0000, 16'h0000, OP_SBC, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, OP_SUB, 1'b0, 1'b0);
    send(16'h1234, 16'h1111, OP_ADC, 1'b1, 1'b0);
`ifdef ADD_SUB_UNIT_SATURATE_EN
    send(16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, OP_SUB, 1'b0, 1'b1);
    send(16'h0100, 16'h0001, OP_ADD, 1'b0, 1'b1);
`endif
    drain();

    c0 = consumed;
    tog = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(16'(i * 16'h1111), 16'(16'h0101 * (i + 1)),
           OP_ADD, 1'b0, 1'b0);
    end
    drain();
    tog = 1'b0;
    hold = 1'b1;
    chk("stream_count", consumed - c0, 8);
    @(posedge clk);
    #1;

    send(16'h1111, 16'h2222, OP_ADD, 1'b0, 1'b0);
    send(16'h3333, 16'h0001, OP_SUB, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid", ov, 0);
    chk("midrst_ready", ir, 1);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", ov, 0);
    end
    @(posedge clk);
    #1;
    send(16'h1234, 16'h1111, OP_SUB, 1'b0, 1'b0);
    drain();

    iv32 = 1'b1;
    ia32 = 32'h0000FFFF;
    ib32 = 32'h00000001;
    iop32 = OP_ADC;
    icin32 = 1'b1;
    ordy32 = 1'b1;
    @(negedge clk);
    chk("ready32", ir32, 1);
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency32", lat, 4);
    m = model(32, 32'h0000FFFF, 32'h1, OP_ADC, 1'b1, 1'b0);
    chk("result32", ores32, m[31:0]);
    chk("flags32", ofl32, m[35:32]);
    @(posedge clk);
    #1;
    chk("drop32", ov32, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
